// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two caches, the arbiter and the word-addressed main memory.
// The slave modport is the arbiter's view; master is the cache/memory side.
interface mem_arbiter_if #(
  parameter int WORD_BITS = 2
);
  logic                 i_req;
  logic [31:0]          i_addr;
  logic                 i_rvalid;
  logic [31:0]          i_rdata;
  logic [WORD_BITS-1:0] i_word;
  logic                 i_done;

  logic                 d_rreq;
  logic [31:0]          d_raddr;
  logic                 d_rvalid;
  logic [31:0]          d_rdata;
  logic [WORD_BITS-1:0] d_word;
  logic                 d_rdone;

  logic                 d_wreq;
  logic [31:0]          d_waddr;
  logic [31:0]          d_wdata;
  logic                 d_wdone;

  logic [31:0]          mem_addr;
  logic [31:0]          mem_wdata;
  logic                 mem_we;
  logic [31:0]          mem_rdata;
  logic                 busy;

  modport slave (
    input  i_req, i_addr, d_rreq, d_raddr, d_wreq, d_waddr, d_wdata, mem_rdata,
    output i_rvalid, i_rdata, i_word, i_done,
    output d_rvalid, d_rdata, d_word, d_rdone, d_wdone,
    output mem_addr, mem_wdata, mem_we, busy
  );

  modport master (
    output i_req, i_addr, d_rreq, d_raddr, d_wreq, d_waddr, d_wdata, mem_rdata,
    input  i_rvalid, i_rdata, i_word, i_done,
    input  d_rvalid, d_rdata, d_word, d_rdone, d_wdone,
    input  mem_addr, mem_wdata, mem_we, busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between I-refill, D-refill and D-write-through.
// Refills stream BLOCK_WORDS words from an aligned base; writes take a single cycle.
//
// state  | meaning
// IDLE   | sample requests, grant one side
// IREAD  | instruction-side burst refill in progress
// DREAD  | data-side burst refill in progress
// DWRITE | single-word write-through on the memory port
module mem_arbiter #(
  parameter int BLOCK_WORDS = 4,
  parameter int WORD_BITS   = 2
) (
  input  logic clk,
  input  logic rst,
  mem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, IREAD, DREAD, DWRITE} state_t;

  localparam logic [WORD_BITS-1:0] CNT_LAST = WORD_BITS'(BLOCK_WORDS - 1);

  state_t               state, state_n;
  logic [WORD_BITS-1:0] cnt, cnt_n;
  logic                 last, last_n;
  logic [31:0]          addr_q, addr_n;
  logic [31:0]          wdata_q, wdata_n;
  logic                 we_q, we_n;
  logic                 d_pend;
  logic                 burst_end;
  logic                 unused_bits;

  // Offset bits inside a block/word are ignored by construction.
  assign unused_bits = ^{bus.i_addr[WORD_BITS+1:0], bus.d_raddr[WORD_BITS+1:0], bus.d_waddr[1:0]};

  assign d_pend    = bus.d_wreq | bus.d_rreq;
  assign burst_end = (cnt == CNT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      last    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      last    <= last_n;
      addr_q  <= addr_n;
      wdata_q <= wdata_n;
      we_q    <= we_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    last_n  = last;
    addr_n  = addr_q;
    wdata_n = wdata_q;
    we_n    = we_q;
    case (state)
      IDLE: begin
        // On a tie the side opposite to the previous grant wins.
        if (d_pend && (!bus.i_req || !last)) begin
          last_n = 1'b1;
          if (bus.d_wreq) begin
            state_n = DWRITE;
            addr_n  = {bus.d_waddr[31:2], 2'b00};
            wdata_n = bus.d_wdata;
            we_n    = 1'b1;
          end else begin
            state_n = DREAD;
            addr_n  = {bus.d_raddr[31:WORD_BITS+2], {(WORD_BITS+2){1'b0}}};
            cnt_n   = '0;
          end
        end else if (bus.i_req) begin
          last_n  = 1'b0;
          state_n = IREAD;
          addr_n  = {bus.i_addr[31:WORD_BITS+2], {(WORD_BITS+2){1'b0}}};
          cnt_n   = '0;
        end
      end
      IREAD, DREAD: begin
        cnt_n = cnt + WORD_BITS'(1);
        if (burst_end) begin
          state_n = IDLE;
        end else begin
          addr_n = addr_q + 32'd4;
        end
      end
      DWRITE: begin
        we_n    = 1'b0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.i_rvalid  = (state == IREAD);
  assign bus.i_rdata   = (state == IREAD) ? bus.mem_rdata : 32'd0;
  assign bus.i_word    = (state == IREAD) ? cnt : '0;
  assign bus.i_done    = (state == IREAD) && burst_end;

  assign bus.d_rvalid  = (state == DREAD);
  assign bus.d_rdata   = (state == DREAD) ? bus.mem_rdata : 32'd0;
  assign bus.d_word    = (state == DREAD) ? cnt : '0;
  assign bus.d_rdone   = (state == DREAD) && burst_end;
  assign bus.d_wdone   = (state == DWRITE);

  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_we    = we_q;
  assign bus.busy      = (state != IDLE);
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: transaction-level model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_mem_arbiter;
  localparam int BW = 4;
  localparam int WB = 2;
  localparam logic [31:0] MASK = ~(32'(BW * 4) - 32'd1);

  typedef enum {K_IDLE, K_I, K_D, K_W} kind_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [31:0] key = 32'd0;

  mem_arbiter_if #(.WORD_BITS(WB)) bus ();

  mem_arbiter #(.BLOCK_WORDS(BW), .WORD_BITS(WB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Memory: word at address a holds a ^ key.
  assign bus.mem_rdata = bus.mem_addr ^ key;

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Transaction-level reference: what is in flight and how far along it is.
  kind_t       m_kind;
  int          m_off;
  logic [31:0] m_base;
  logic [31:0] m_hold_addr;
  logic [31:0] m_hold_wdata;
  logic        m_last_d;
  int          grants[$];

  bit rnd_mode = 0;
  bit persist  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  function automatic void model_reset();
    m_kind       = K_IDLE;
    m_off        = 0;
    m_base       = 32'd0;
    m_hold_addr  = 32'd0;
    m_hold_wdata = 32'd0;
    m_last_d     = 1'b0;
  endfunction

  function automatic void model_advance();
    bit ip, dp, pick_d;
    case (m_kind)
      K_I, K_D: begin
        if (m_off == BW - 1) begin
          m_hold_addr = m_base + 32'(4 * m_off);
          m_kind = K_IDLE;
        end else m_off++;
      end
      K_W: m_kind = K_IDLE;
      default: begin
        ip = bus.i_req;
        dp = bus.d_wreq | bus.d_rreq;
        pick_d = ip && dp ? !m_last_d : dp;
        if (pick_d) begin
          m_last_d = 1'b1;
          grants.push_back(1);
          if (bus.d_wreq) begin
            m_kind = K_W;
            m_hold_addr  = bus.d_waddr & 32'hFFFF_FFFC;
            m_hold_wdata = bus.d_wdata;
          end else begin
            m_kind = K_D;
            m_off  = 0;
            m_base = bus.d_raddr & MASK;
          end
        end else if (ip) begin
          m_last_d = 1'b0;
          grants.push_back(0);
          m_kind = K_I;
          m_off  = 0;
          m_base = bus.i_addr & MASK;
        end
      end
    endcase
  endfunction

  task automatic compare();
    logic [31:0] a;
    bit rd, last_word;
    rd = (m_kind == K_I) || (m_kind == K_D);
    a = rd ? m_base + 32'(4 * m_off) : m_hold_addr;
    last_word = rd && (m_off == BW - 1);
    chk("i_rvalid", 32'(bus.i_rvalid), 32'(m_kind == K_I));
    chk("i_rdata",  bus.i_rdata, (m_kind == K_I) ? (a ^ key) : 32'd0);
    chk("i_word",   32'(bus.i_word), (m_kind == K_I) ? 32'(m_off) : 32'd0);
    chk("i_done",   32'(bus.i_done), 32'((m_kind == K_I) && last_word));
    chk("d_rvalid", 32'(bus.d_rvalid), 32'(m_kind == K_D));
    chk("d_rdata",  bus.d_rdata, (m_kind == K_D) ? (a ^ key) : 32'd0);
    chk("d_word",   32'(bus.d_word), (m_kind == K_D) ? 32'(m_off) : 32'd0);
    chk("d_rdone",  32'(bus.d_rdone), 32'((m_kind == K_D) && last_word));
    chk("d_wdone",  32'(bus.d_wdone), 32'(m_kind == K_W));
    chk("mem_we",   32'(bus.mem_we), 32'(m_kind == K_W));
    chk("mem_addr", bus.mem_addr, a);
    chk("mem_wdata", bus.mem_wdata, m_hold_wdata);
    chk("busy",     32'(bus.busy), 32'(m_kind != K_IDLE));
  endtask

  // One clock: advance the model at the edge, compare mid-cycle, then act as requesters.
  task automatic tick();
    @(posedge clk);
    cyc++;
    if (rst) model_reset(); else model_advance();
    @(negedge clk);
    compare();
    if (!persist) begin
      if (m_kind == K_I && m_off == BW - 1) bus.i_req = 1'b0;
      if (m_kind == K_D && m_off == BW - 1) bus.d_rreq = 1'b0;
      if (m_kind == K_W) bus.d_wreq = 1'b0;
    end
    if (rnd_mode) begin
      if (!bus.i_req && $urandom_range(3) == 0) begin
        bus.i_req = 1'b1; bus.i_addr = $urandom;
      end
      if (!bus.d_rreq && $urandom_range(3) == 0) begin
        bus.d_rreq = 1'b1; bus.d_raddr = $urandom;
      end
      if (!bus.d_wreq && $urandom_range(4) == 0) begin
        bus.d_wreq = 1'b1; bus.d_waddr = $urandom; bus.d_wdata = $urandom;
      end
    end
  endtask

  task automatic do_reset();
    bus.i_req = 1'b0; bus.d_rreq = 1'b0; bus.d_wreq = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog cycle %0d: got timeout expected finish", cyc);
    $fatal(1);
  end

  initial begin
    bus.i_req = 1'b0; bus.i_addr = 32'd0;
    bus.d_rreq = 1'b0; bus.d_raddr = 32'd0;
    bus.d_wreq = 1'b0; bus.d_waddr = 32'd0; bus.d_wdata = 32'd0;
    model_reset();
    do_reset();

    // Instruction-only refill from 0x124.
    bus.i_req = 1'b1; bus.i_addr = 32'h0000_0124;
    for (int k = 0; k < BW; k++) begin
      tick();
      chk("lit_i_rvalid", 32'(bus.i_rvalid), 32'd1);
      chk("lit_i_addr", bus.mem_addr, 32'h120 + 32'(4 * k));
      chk("lit_i_rdata", bus.i_rdata, 32'h120 + 32'(4 * k));
      chk("lit_i_word", 32'(bus.i_word), 32'(k));
      chk("lit_i_done", 32'(bus.i_done), 32'(k == 3));
    end
    tick();
    chk("lit_i_idle_busy", 32'(bus.busy), 32'd0);

    // Write and data refill together right after reset: write first.
    do_reset();
    bus.d_wreq = 1'b1; bus.d_waddr = 32'h40; bus.d_wdata = 32'hDEAD_BEEF;
    bus.d_rreq = 1'b1; bus.d_raddr = 32'h80;
    tick();
    chk("lit_w_we", 32'(bus.mem_we), 32'd1);
    chk("lit_w_addr", bus.mem_addr, 32'h40);
    chk("lit_w_data", bus.mem_wdata, 32'hDEAD_BEEF);
    chk("lit_w_done", 32'(bus.d_wdone), 32'd1);
    tick();
    chk("lit_w_idle_we", 32'(bus.mem_we), 32'd0);
    chk("lit_w_idle_busy", 32'(bus.busy), 32'd0);
    tick();
    chk("lit_dr_valid", 32'(bus.d_rvalid), 32'd1);
    chk("lit_dr_addr", bus.mem_addr, 32'h80);
    for (int k = 1; k < BW + 2; k++) tick();

    // Continuous contention: grants alternate D, I, D, I.
    do_reset();
    grants.delete();
    persist = 1;
    bus.i_req = 1'b1; bus.i_addr = 32'h1000;
    bus.d_rreq = 1'b1; bus.d_raddr = 32'h2000;
    for (int k = 0; k < 4 * (BW + 1) + 1; k++) tick();
    chk("alt_grant_count", 32'(grants.size() >= 4), 32'd1);
    for (int j = 0; j < 4 && j < grants.size(); j++)
      chk("alt_grant_side", 32'(grants[j]), (j % 2 == 0) ? 32'd1 : 32'd0);
    persist = 0;

    // Data request arriving during an instruction burst waits; no grant in the done cycle.
    do_reset();
    bus.i_req = 1'b1; bus.i_addr = 32'h500;
    tick();
    bus.d_rreq = 1'b1; bus.d_raddr = 32'h600;
    for (int k = 1; k < BW; k++) begin
      tick();
      chk("cont_d_rvalid", 32'(bus.d_rvalid), 32'd0);
      chk("cont_d_rdone", 32'(bus.d_rdone), 32'd0);
    end
    tick();
    chk("cont_gap_busy", 32'(bus.busy), 32'd0);
    tick();
    chk("cont_d_start", 32'(bus.d_rvalid), 32'd1);
    chk("cont_d_word0", 32'(bus.d_word), 32'd0);
    chk("cont_d_addr", bus.mem_addr, 32'h600);
    for (int k = 1; k < BW + 1; k++) tick();

    // Reset during the third word of a data refill.
    do_reset();
    bus.d_rreq = 1'b1; bus.d_raddr = 32'h300;
    for (int k = 0; k < 3; k++) tick();
    chk("rst_pre_word", 32'(bus.d_word), 32'd2);
    rst = 1'b1;
    #1;
    chk("rst_d_rvalid", 32'(bus.d_rvalid), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_mem_addr", bus.mem_addr, 32'd0);
    model_reset();
    tick();
    rst = 1'b0;
    tick();
    chk("rst_restart_word", 32'(bus.d_word), 32'd0);
    chk("rst_restart_addr", bus.mem_addr, 32'h300);
    chk("rst_restart_valid", 32'(bus.d_rvalid), 32'd1);
    for (int k = 1; k < BW + 1; k++) tick();

    // Randomized traffic against the model.
    do_reset();
    key = $urandom;
    rnd_mode = 1;
    for (int k = 0; k < 3000; k++) tick();
    rnd_mode = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
